// File: rtl/alu_wb_stage.sv
// alu_wb_stage
// Registered result stage that sits directly after the 32-bit ALU. It
// captures the ALU result, derives N/Z/C/V flags and hands results to
// writeback over a valid/ready handshake. A two-entry skid buffer (main +
// skid) lets in_ready be a flop output while still sustaining one result
// per cycle. The stage also holds the committed architectural flags.
//
// Optional build macro: ALU_WB_OVERFLOW_EN
//   defined   -> V flag is computed; out_flags[0] and flags_q[0] are live
//   undefined -> no V logic; out_flags[0] and flags_q[0] are always 0
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid/in_ready   upstream handshake (in_ready is registered)
//   in_op               ALU code: 000 NOT 001 AND 010 ASR 011 XOR 100 ADD 101 SUB
//   in_a, in_b          ALU operands (used for V only)
//   in_dout, in_cout    ALU result and carry/borrow out
//   in_rd               destination register tag
//   out_valid/out_ready downstream handshake to writeback
//   out_data, out_rd    result and tag of the oldest entry
//   out_flags           {N,Z,C,V} of the oldest entry
//   flags_q             committed {N,Z,C,V}, updated when an entry pops
//   illegal             one-cycle pulse after an illegal opcode is dropped
module alu_wb_stage #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [DATA_W-1:0] in_dout,
    input  logic              in_cout,
    input  logic [RD_W-1:0]   in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [RD_W-1:0]   out_rd,
    output logic [3:0]        out_flags,
    output logic [3:0]        flags_q,
    output logic              illegal
);

    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

    // Main entry drives out_*; skid entry holds the overflow result.
    logic              mainValid_q, mainValid_d;
    logic [DATA_W-1:0] mainData_q,  mainData_d;
    logic [RD_W-1:0]   mainRd_q,    mainRd_d;
    logic [3:0]        mainFlags_q, mainFlags_d;
    logic              mainArith_q, mainArith_d;

    logic              skidValid_q, skidValid_d;
    logic [DATA_W-1:0] skidData_q,  skidData_d;
    logic [RD_W-1:0]   skidRd_q,    skidRd_d;
    logic [3:0]        skidFlags_q, skidFlags_d;
    logic              skidArith_q, skidArith_d;

    logic              inReady_q,   inReady_d;
    logic [3:0]        flags_d;
    logic              illegal_q,   illegal_d;

    logic              inLegal, inArith, accept, pop, load;
    logic [3:0]        newFlags;
    logic              newV;

    // Opcode classification and per-result flag derivation at accept time.
    always_comb begin
        inLegal = (in_op <= OP_SUB);
        inArith = (in_op == OP_ADD) || (in_op == OP_SUB);
        newV    = 1'b0;
`ifdef ALU_WB_OVERFLOW_EN
        // ADD overflows when like-signed operands give a different sign;
        // SUB overflows when unlike-signed operands flip the sign of A.
        if (in_op == OP_ADD) begin
            newV = (in_a[DATA_W-1] == in_b[DATA_W-1]) &&
                   (in_dout[DATA_W-1] != in_a[DATA_W-1]);
        end else if (in_op == OP_SUB) begin
            newV = (in_a[DATA_W-1] != in_b[DATA_W-1]) &&
                   (in_dout[DATA_W-1] != in_a[DATA_W-1]);
        end
`endif
        newFlags = {in_dout[DATA_W-1], (in_dout == '0), inArith & in_cout, newV};
    end

`ifdef ALU_WB_OVERFLOW_EN
    logic unusedOperandBits;
    assign unusedOperandBits = ^{in_a[DATA_W-2:0], in_b[DATA_W-2:0]};
`else
    logic unusedOperandBits;
    assign unusedOperandBits = ^{in_a, in_b};
`endif

    // Skid-buffer next state. A pop with the skid full cannot coincide with
    // an accept, because in_ready is low whenever the skid holds data.
    always_comb begin
        mainValid_d = mainValid_q;
        mainData_d  = mainData_q;
        mainRd_d    = mainRd_q;
        mainFlags_d = mainFlags_q;
        mainArith_d = mainArith_q;
        skidValid_d = skidValid_q;
        skidData_d  = skidData_q;
        skidRd_d    = skidRd_q;
        skidFlags_d = skidFlags_q;
        skidArith_d = skidArith_q;
        flags_d     = flags_q;

        accept = in_valid & inReady_q;
        pop    = mainValid_q & out_ready;
        load   = accept & inLegal;

        if (pop && skidValid_q) begin
            mainData_d  = skidData_q;
            mainRd_d    = skidRd_q;
            mainFlags_d = skidFlags_q;
            mainArith_d = skidArith_q;
            skidValid_d = 1'b0;
        end else if (load) begin
            if (!mainValid_q || pop) begin
                mainValid_d = 1'b1;
                mainData_d  = in_dout;
                mainRd_d    = in_rd;
                mainFlags_d = newFlags;
                mainArith_d = inArith;
            end else begin
                skidValid_d = 1'b1;
                skidData_d  = in_dout;
                skidRd_d    = in_rd;
                skidFlags_d = newFlags;
                skidArith_d = inArith;
            end
        end else if (pop) begin
            mainValid_d = 1'b0;
        end

        // Logic ops only own N and Z; C and V survive from the last arith op.
        if (pop) begin
            if (mainArith_q) begin
                flags_d = mainFlags_q;
            end else begin
                flags_d = {mainFlags_q[3:2], flags_q[1:0]};
            end
        end
`ifndef ALU_WB_OVERFLOW_EN
        flags_d[0] = 1'b0;
`endif

        inReady_d = !skidValid_d;
        illegal_d = accept & !inLegal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mainValid_q <= 1'b0;
            mainData_q  <= '0;
            mainRd_q    <= '0;
            mainFlags_q <= '0;
            mainArith_q <= 1'b0;
            skidValid_q <= 1'b0;
            skidData_q  <= '0;
            skidRd_q    <= '0;
            skidFlags_q <= '0;
            skidArith_q <= 1'b0;
            inReady_q   <= 1'b1;
            flags_q     <= '0;
            illegal_q   <= 1'b0;
        end else begin
            mainValid_q <= mainValid_d;
            mainData_q  <= mainData_d;
            mainRd_q    <= mainRd_d;
            mainFlags_q <= mainFlags_d;
            mainArith_q <= mainArith_d;
            skidValid_q <= skidValid_d;
            skidData_q  <= skidData_d;
            skidRd_q    <= skidRd_d;
            skidFlags_q <= skidFlags_d;
            skidArith_q <= skidArith_d;
            inReady_q   <= inReady_d;
            flags_q     <= flags_d;
            illegal_q   <= illegal_d;
        end
    end

    assign in_ready  = inReady_q;
    assign out_valid = mainValid_q;
    assign out_data  = mainData_q;
    assign out_rd    = mainRd_q;
    assign out_flags = mainFlags_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_wb_stage.sv
// tb_alu_wb_stage
// Drives alu_wb_stage with directed and randomized ALU results and compares
// every cycle against a queue-based reference model of a two-deep FIFO
// with committed flags.
module tb_alu_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = '0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [31:0] in_dout = '0;
    logic        in_cout = 1'b0;
    logic [4:0]  in_rd = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic [3:0]  out_flags;
    logic [3:0]  flags_q;
    logic        illegal;

    alu_wb_stage #(.DATA_W(32), .RD_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_dout(in_dout), .in_cout(in_cout),
        .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_rd(out_rd), .out_flags(out_flags), .flags_q(flags_q),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic [3:0]  flags;
        logic        arith;
    } entry_t;

    entry_t      modelQ[$];
    logic [3:0]  modelFlags = '0;
    logic        modelIllegal = 1'b0;
    int          checkCount = 0;
    int          errorCount = 0;

    // Count one comparison and report it if the values differ.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Flags as an architect would define them, using plain signed arithmetic
    // for overflow instead of sign-bit comparisons.
    function automatic logic [3:0] refFlags(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] dout,
                                            input logic cout);
        logic n, z, c, v;
        longint s;
        n = dout[31];
        z = (dout == 32'd0);
        c = (op == 3'd4 || op == 3'd5) ? cout : 1'b0;
        v = 1'b0;
`ifdef ALU_WB_OVERFLOW_EN
        if (op == 3'd4 || op == 3'd5) begin
            if (op == 3'd4) s = longint'($signed(a)) + longint'($signed(b));
            else            s = longint'($signed(a)) - longint'($signed(b));
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
`endif
        return {n, z, c, v};
    endfunction

    // Present one ALU result on the inputs, playing the role of the ALU.
    task automatic aluDrive(input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] rd, input logic valid);
        logic signed [31:0] sa;
        logic [32:0] wide;
        in_valid = valid;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_rd    = rd;
        sa       = a;
        in_cout  = 1'b0;
        case (op)
            3'd0: in_dout = ~a;
            3'd1: in_dout = a & b;
            3'd2: in_dout = sa >>> b[4:0];
            3'd3: in_dout = a ^ b;
            3'd4: begin
                wide    = {1'b0, a} + {1'b0, b};
                in_dout = wide[31:0];
                in_cout = wide[32];
            end
            3'd5: begin
                in_dout = a - b;
                in_cout = (a < b);
            end
            default: begin
                in_dout = $urandom;
                in_cout = 1'($urandom_range(0, 1));
            end
        endcase
    endtask

    // Compare every visible output against the model.
    task automatic compareAll();
        checkOutput("out_valid", out_valid, modelQ.size() > 0);
        checkOutput("in_ready", in_ready, modelQ.size() < 2);
        if (modelQ.size() > 0) begin
            checkOutput("out_data", out_data, modelQ[0].data);
            checkOutput("out_rd", out_rd, modelQ[0].rd);
            checkOutput("out_flags", out_flags, modelQ[0].flags);
        end
        checkOutput("flags_q", flags_q, modelFlags);
        checkOutput("illegal", illegal, modelIllegal);
    endtask

    // Run one clock with the currently driven inputs, advance the model,
    // then check the outputs on the falling edge.
    task automatic applyStimulus();
        logic acc, popNow, legal;
        entry_t e;
        acc    = in_valid && (modelQ.size() < 2);
        popNow = (modelQ.size() > 0) && out_ready;
        legal  = (in_op <= 3'd5);
        e.data  = in_dout;
        e.rd    = in_rd;
        e.flags = refFlags(in_op, in_a, in_b, in_dout, in_cout);
        e.arith = (in_op == 3'd4 || in_op == 3'd5);
        @(posedge clk);
        if (popNow) begin
            entry_t p;
            p = modelQ.pop_front();
            modelFlags = p.arith ? p.flags : {p.flags[3:2], modelFlags[1:0]};
        end
        if (acc && legal) modelQ.push_back(e);
        modelIllegal = acc && !legal;
        @(negedge clk);
        compareAll();
    endtask

    task automatic idle(input logic ready, input int cycles);
        in_valid  = 1'b0;
        out_ready = ready;
        for (int i = 0; i < cycles; i++) applyStimulus();
    endtask

    // Reset in the middle of a cycle and check the immediate effect.
    task automatic midCycleReset();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_in_ready", in_ready, 1'b1);
        checkOutput("rst_flags_q", flags_q, 4'b0000);
        checkOutput("rst_out_data", out_data, 32'd0);
        checkOutput("rst_illegal", illegal, 1'b0);
        modelQ.delete();
        modelFlags   = '0;
        modelIllegal = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] ra, rb;
        // Reset values.
        repeat (2) @(negedge clk);
        checkOutput("reset_out_valid", out_valid, 1'b0);
        checkOutput("reset_in_ready", in_ready, 1'b1);
        checkOutput("reset_out_data", out_data, 32'd0);
        checkOutput("reset_out_rd", out_rd, 5'd0);
        checkOutput("reset_out_flags", out_flags, 4'd0);
        checkOutput("reset_flags_q", flags_q, 4'd0);
        checkOutput("reset_illegal", illegal, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD wrapping to zero with carry.
        aluDrive(3'd4, 32'hFFFF_FFFF, 32'd1, 5'd3, 1'b1);
        out_ready = 1'b1;
        applyStimulus();
        checkOutput("add_valid", out_valid, 1'b1);
        checkOutput("add_data", out_data, 32'd0);
        checkOutput("add_rd", out_rd, 5'd3);
        checkOutput("add_flags", out_flags, 4'b0110);
        idle(1'b1, 1);
        checkOutput("add_commit", flags_q, 4'b0110);

        // SUB overflowing from most-negative.
        aluDrive(3'd5, 32'h8000_0000, 32'd1, 5'd7, 1'b1);
        out_ready = 1'b0;
        applyStimulus();
        checkOutput("sub_data", out_data, 32'h7FFF_FFFF);
`ifdef ALU_WB_OVERFLOW_EN
        checkOutput("sub_flags", out_flags, 4'b0001);
`else
        checkOutput("sub_flags", out_flags, 4'b0000);
`endif
        idle(1'b1, 1);

        // Back-to-back ADDs fill main and skid, then drain in order.
        out_ready = 1'b0;
        aluDrive(3'd4, 32'd10, 32'd20, 5'd1, 1'b1);
        applyStimulus();
        aluDrive(3'd4, 32'd100, 32'd200, 5'd2, 1'b1);
        applyStimulus();
        checkOutput("skid_in_ready", in_ready, 1'b0);
        idle(1'b0, 2);
        out_ready = 1'b1;
        applyStimulus();
        checkOutput("skid_pop_ready", in_ready, 1'b1);
        checkOutput("skid_second", out_data, 32'd300);
        idle(1'b1, 2);

        // C preserved across a logic op.
        aluDrive(3'd4, 32'hFFFF_FFFF, 32'd2, 5'd4, 1'b1);
        out_ready = 1'b1;
        applyStimulus();
        idle(1'b1, 1);
        checkOutput("c_set", flags_q, 4'b0010);
        aluDrive(3'd3, 32'h8000_0000, 32'd0, 5'd5, 1'b1);
        applyStimulus();
        idle(1'b1, 1);
        checkOutput("xor_keep_c", flags_q, 4'b1010);

        // Illegal opcode dropped with a single pulse.
        aluDrive(3'd6, 32'd1, 32'd2, 5'd6, 1'b1);
        applyStimulus();
        checkOutput("illegal_pulse", illegal, 1'b1);
        checkOutput("illegal_no_valid", out_valid, 1'b0);
        idle(1'b1, 1);
        checkOutput("illegal_done", illegal, 1'b0);
        checkOutput("illegal_flags", flags_q, 4'b1010);

        // Reset with the skid full.
        out_ready = 1'b0;
        aluDrive(3'd4, 32'd1, 32'd1, 5'd8, 1'b1);
        applyStimulus();
        aluDrive(3'd5, 32'd1, 32'd2, 5'd9, 1'b1);
        applyStimulus();
        midCycleReset();
        idle(1'b1, 3);

        // Randomized traffic with occasional mid-cycle resets.
        for (int i = 0; i < 3000; i++) begin
            ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            aluDrive(3'($urandom_range(0, 7)), ra, rb, 5'($urandom),
                     $urandom_range(0, 3) != 0);
            out_ready = $urandom_range(0, 3) != 0;
            applyStimulus();
            if ($urandom_range(0, 499) == 0) midCycleReset();
        end
        idle(1'b1, 3);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
